sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx_if.sv | 23 ++
 rtl/sipo_rx.sv | 73 +++++++
 tb/tb_sipo_rx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// Serial-in bit stream and parallel-out word handshake for sipo_rx.
interface sipo_rx_if #(
  parameter int WIDTH = 4
);
  logic             bit_valid_i;
  logic             start_i;
  logic             data_i;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             busy_o;
  logic             overrun_o;

  modport master (
    output bit_valid_i, start_i, data_i, ready_i,
    input  data_o, valid_o, busy_o, overrun_o
  );

  modport slave (
    input  bit_valid_i, start_i, data_i, ready_i,
    output data_o, valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with a one-word output holding register.
//   state | meaning
//   IDLE  | waiting for a valid start bit
//   SHIFT | word partially received, count_q bits so far
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  sipo_rx_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;

  logic [WIDTH-1:0] shift_d;
  logic             last_bit;

  assign shift_d  = {bus.data_i, shift_q[WIDTH-1:1]};
  assign last_bit = bus.bit_valid_i && !bus.start_i && (state_q == SHIFT) &&
                    (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // A start bit always begins a fresh word, aborting any partial one.
      if (bus.bit_valid_i) begin
        if (bus.start_i) begin
          shift_q <= {bus.data_i, {(WIDTH-1){1'b0}}};
          count_q <= CW'(1);
          state_q <= SHIFT;
        end else if (state_q == SHIFT) begin
          shift_q <= shift_d;
          if (last_bit) begin
            count_q <= '0;
            state_q <= IDLE;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
      end

      if (last_bit) begin
        if (!valid_q || bus.ready_i) begin
          data_q  <= shift_d;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = (state_q == SHIFT);
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_sipo_rx.sv
// Randomized and directed bench for sipo_rx against a bit-queue reference model.
module tb_sipo_rx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sipo_rx_if #(.WIDTH(W)) bus ();
  sipo_rx #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference model: bits collected since the last start, plus output holding state
  bit         m_bits[$];
  bit         m_busy;
  logic [W-1:0] m_data;
  bit         m_valid;
  bit         m_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    m_busy  = 0;
    m_data  = '0;
    m_valid = 0;
    m_ovr   = 0;
  endfunction

  function automatic void model_edge(bit bv, bit st, bit d, bit rdy);
    bit           done = 0;
    logic [W-1:0] word = '0;
    if (bv) begin
      if (st) begin
        m_bits.delete();
        m_bits.push_back(d);
        m_busy = 1;
      end else if (m_busy) begin
        m_bits.push_back(d);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) word = word + (W'(m_bits[i]) << i);
          done = 1;
          m_busy = 0;
          m_bits.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = word;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".data"},    32'(bus.data_o),    32'(m_data));
    chk({tag, ".valid"},   32'(bus.valid_o),   32'(m_valid));
    chk({tag, ".busy"},    32'(bus.busy_o),    32'(m_busy));
    chk({tag, ".overrun"}, 32'(bus.overrun_o), 32'(m_ovr));
  endtask

  // inputs change 1 time unit after the rising edge; outputs checked right after
  task automatic step(input bit bv, input bit st, input bit d, input string tag);
    bus.bit_valid_i = bv;
    bus.start_i     = st;
    bus.data_i      = d;
    @(posedge clk);
    model_edge(bv, st, d, bus.ready_i);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input string tag);
    logic [W-1:0] v;
    v = w;
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0, v[i], tag);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, {tag, ".gap"});
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rw;
    bus.bit_valid_i = 0;
    bus.start_i     = 0;
    bus.data_i      = 0;
    bus.ready_i     = 1;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // back-to-back word, then exactly one valid cycle
    send_word(4'hB, 0, "b2b");
    chk("b2b.word", 32'(bus.data_o), 32'hB);
    chk("b2b.vld", 32'(bus.valid_o), 32'd1);
    step(0, 0, 0, "b2b.after");
    chk("b2b.vclr", 32'(bus.valid_o), 32'd0);

    send_word(4'hB, 3, "gaps");
    step(0, 0, 0, "gaps.drain");
    chk("gaps.word", 32'(bus.data_o), 32'hB);

    // overrun then drain
    bus.ready_i = 0;
    send_word(4'hB, 0, "ovr1");
    send_word(4'h6, 0, "ovr2");
    chk("ovr.data", 32'(bus.data_o), 32'hB);
    chk("ovr.flag", 32'(bus.overrun_o), 32'd1);
    bus.ready_i = 1;
    step(0, 0, 0, "ovr.drain");
    chk("ovr.vclr", 32'(bus.valid_o), 32'd0);

    async_reset("rst1");
    chk("rst1.ovr", 32'(bus.overrun_o), 32'd0);

    // accept-and-replace on completion edge
    bus.ready_i = 0;
    send_word(4'hB, 0, "rep1");
    step(1, 1, 0, "rep2");
    step(1, 0, 1, "rep2");
    step(1, 0, 1, "rep2");
    bus.ready_i = 1;
    step(1, 0, 0, "rep2");
    chk("rep.data", 32'(bus.data_o), 32'h6);
    chk("rep.vld", 32'(bus.valid_o), 32'd1);
    chk("rep.ovr", 32'(bus.overrun_o), 32'd0);

    // abort by restart
    step(1, 1, 1, "abort");
    step(1, 0, 1, "abort");
    send_word(4'h5, 0, "abort.word");
    chk("abort.data", 32'(bus.data_o), 32'h5);
    chk("abort.ovr", 32'(bus.overrun_o), 32'd0);

    // reset mid-word, unstarted bits ignored
    step(1, 1, 1, "midrst");
    step(1, 0, 0, "midrst");
    async_reset("midrst");
    for (int i = 0; i < 5; i++) step(1, 0, 1, "nostart");
    chk("nostart.busy", 32'(bus.busy_o), 32'd0);
    send_word(4'h3, 0, "w3");
    chk("w3.data", 32'(bus.data_o), 32'h3);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rnd.rst");
      end else if ($urandom_range(0, 19) == 0) begin
        rw = W'($urandom);
        send_word(rw, $urandom_range(0, 2), "rnd.word");
      end else begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
             $urandom_range(0, 1) == 1, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
